dmem_responder: RTL and testbench
=================================

# dmem_responder

Handshaked data-memory responder for the MIPS datapath: the target side of the CPU's load/store path. Accepts one word/byte read or write request at a time over a valid/ready channel, inserts a fixed number of wait states, performs the access on an internal 256 × 32 array and returns a response over a second valid/ready channel. A combinational debug port exposes the low 16 words to the segment-display logic.

## Interface
Parameters:
- `WAIT_CYCLES`, default 2: wait states between request accept and array access; legal range 0–15.
- `DBG_AW`, default 4: debug word-address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_byte` in 1: 1 = byte access (lb/sb), 0 = word access (lw/sw).
- `req_addr` in 10: byte address (CPU `ALU[9:0]`).
- `req_wdata` in 32: store data; byte stores use `[7:0]`.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: initiator takes the response.
- `rsp_rdata` out 32: load data; byte loads are zero-extended (the initiator sign-extends); 0 for stores and errors.
- `rsp_err` out 1: misaligned word access.
- `dbg_addr` in DBG_AW: debug word index.
- `dbg_data` out 32: `mem[dbg_addr]`, combinational.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. When `req_valid`=1, capture `req_*` into request registers. Go to WAIT with `wcnt`=WAIT_CYCLES, or directly to RESP if WAIT_CYCLES=0 (the access is performed on the transition edge).
- WAIT: `req_ready`=0. Decrement `wcnt`. On the edge where `wcnt`=1, perform the access and go to RESP.
- RESP: `rsp_valid`=1. `rsp_rdata` and `rsp_err` are registered and stable. On `rsp_ready`=1, go to IDLE. While `rsp_ready`=0, hold all response outputs.
- Access rules:
  - Word index is `addr[9:2]`.
  - Byte lane is `addr[1:0]`, little-endian: lane 0 = bits [7:0].
  - Word load: `rdata`=`mem[idx]`.
  - Byte load: `rdata`={24'b0, selected lane}.
  - Word store: write all 4 lanes.
  - Byte store: write only the selected lane.
- Misaligned word access (`req_byte`=0 and `addr[1:0]`≠0): no array change, `rsp_err`=1, `rsp_rdata`=0. Byte accesses are never misaligned.
- Stores always produce a response (acknowledge) with `rsp_rdata`=0.
- Reset (asynchronous, any state):
  - FSM goes to IDLE.
  - `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - All array words are cleared to 0.
  - Any in-flight request is dropped, with no partial write.

## Timing
- Accept happens on the edge with `req_valid`&`req_ready`.
- `rsp_valid` rises WAIT_CYCLES+1 edges after accept.
- Minimum request-to-request spacing is WAIT_CYCLES+2 cycles when `rsp_ready` is held at 1.
- `req_ready` is 0 from the accept edge until the edge that completes the response. A request issued in the same cycle as the completing `rsp_ready` is not accepted; it is taken on the next cycle.
- `dbg_data` reflects a write in the cycle after that write's edge.
- Same-cycle debug read and array write: the debug port shows the old value.

## Configuration
- Macro `DMEM_STATS_EN`.
- Defined: adds outputs `rd_cnt` (out, 16) and `wr_cnt` (out, 16).
  - Each is a saturating count of completed non-error loads and stores, counted on the response-completion edge.
  - Both stick at 16'hFFFF and reset to 0.
- Undefined: the counters and ports are absent; all other behaviour is identical.

## Structure
- Package `dmem_pkg` holds:
  - State enum `dmem_state_t` {IDLE, WAIT, RESP}.
  - `DMEM_WORDS`=256.
  - `DMEM_AW`=10.
  - Function `lane_mask(addr[1:0], byte)` returning a 4-bit write enable.
- Sub-module `dmem_array`: 256 × 32 storage with 4-bit byte write enable, asynchronous clear, one registered-write/combinational-read port, and the combinational debug read port. The FSM and response registers live in `dmem_responder`.

## Test plan
- Reset, then word store addr 0x008 data 0xDEADBEEF, then word load 0x008:
  - Store ack with `rsp_rdata`=0, `rsp_err`=0.
  - Load returns 0xDEADBEEF.
  - `dbg_addr`=2 shows 0xDEADBEEF.
- Byte store 0x55 to addr 0x009 over word 0xDEADBEEF, then word load 0x008 returns 0xDEAD55EF. Byte load 0x00B returns 0x000000DE.
- Word load from addr 0x006: `rsp_err`=1, `rsp_rdata`=0. Word store to 0x005: `rsp_err`=1 and array word 1 unchanged.
- WAIT_CYCLES=2 with `rsp_ready` held low 5 cycles:
  - `rsp_valid` rises exactly 3 edges after accept and holds data stable.
  - `req_ready` stays 0 throughout and rises the cycle after `rsp_ready`.
- `RST` asserted while in WAIT of a store to 0x010:
  - Immediately `rsp_valid`=0 and `req_ready`=1.
  - After release, load 0x010 returns 0.
- With `DMEM_STATS_EN`:
  - 3 loads, 2 stores and 1 misaligned load give `rd_cnt`=3, `wr_cnt`=2.
  - Forced `rd_cnt`=0xFFFF plus one more load stays 0xFFFF.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  localparam int DMEM_WORDS = 256;
  localparam int DMEM_AW    = 10;
  localparam int DMEM_IW    = 8;

  // Byte write enable for an access: one lane for byte stores, all four for words.
  function automatic logic [3:0] lane_mask(input logic [1:0] lane, input logic is_byte);
    lane_mask = is_byte ? (4'b0001 << lane) : 4'b1111;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// 256 x 32 word store with byte write enables and a combinational debug read port.
// Latency: writes land on the clock edge, reads are combinational (old value during a write cycle).
// Backpressure: none; the array accepts a write on every cycle its enable is set.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DBG_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         we,
  input  logic [DMEM_IW-1:0] idx,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [DBG_AW-1:0]  dbg_addr,
  output logic [31:0]        dbg_data
);

  logic [31:0] mem [DMEM_WORDS];

  // Clear every word on reset; otherwise write only the enabled byte lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (we[l]) begin
          mem[idx][8*l +: 8] <= wdata[8*l +: 8];
        end
      end
    end
  end

  assign rdata    = mem[idx];
  assign dbg_data = mem[DMEM_IW'(dbg_addr)];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory target: one load/store at a time against a 256 x 32 array (stats counters with DMEM_STATS_EN).
// Latency: rsp_valid rises WAIT_CYCLES+1 edges after the accept edge (accept edge counted as the first).
// Backpressure: req_ready low from accept until the response completes; response held while rsp_ready is low.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DBG_AW      = 4
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic               req_byte,
  input  logic [DMEM_AW-1:0] req_addr,
  input  logic [31:0]        req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_rdata,
  output logic               rsp_err,
  input  logic [DBG_AW-1:0]  dbg_addr,
  output logic [31:0]        dbg_data
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]        rd_cnt,
  output logic [15:0]        wr_cnt
`endif
);

  localparam logic [3:0] WCNT_INIT = 4'(WAIT_CYCLES);

  dmem_state_t        state, state_nxt;
  logic [3:0]         wcnt, wcnt_nxt;
  logic               capture, do_access;
  logic               r_we, r_byte;
  logic [DMEM_AW-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic               a_we, a_byte, a_mis;
  logic [DMEM_AW-1:0] a_addr;
  logic [31:0]        a_wdata;
  logic [3:0]         arr_we;
  logic [31:0]        arr_wdata, arr_rdata, load_data;
  logic [7:0]         lane_byte;

  // With zero wait states the access happens on the accept edge, so use the live request then.
  assign a_we    = (state == IDLE) ? req_we    : r_we;
  assign a_byte  = (state == IDLE) ? req_byte  : r_byte;
  assign a_addr  = (state == IDLE) ? req_addr  : r_addr;
  assign a_wdata = (state == IDLE) ? req_wdata : r_wdata;
  assign a_mis   = !a_byte && (a_addr[1:0] != 2'b00);

  assign arr_we    = (do_access && a_we && !a_mis) ? lane_mask(a_addr[1:0], a_byte) : 4'b0000;
  assign arr_wdata = a_byte ? {4{a_wdata[7:0]}} : a_wdata;
  assign load_data = a_byte ? {24'b0, lane_byte} : arr_rdata;

  // Little-endian lane pick for byte loads.
  always_comb begin
    lane_byte = arr_rdata[7:0];
    case (a_addr[1:0])
      2'd1:    lane_byte = arr_rdata[15:8];
      2'd2:    lane_byte = arr_rdata[23:16];
      2'd3:    lane_byte = arr_rdata[31:24];
      default: lane_byte = arr_rdata[7:0];
    endcase
  end

  // Next state, wait counter and handshake outputs.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    capture   = 1'b0;
    do_access = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_nxt = RESP;
          end else begin
            wcnt_nxt  = WCNT_INIT;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        wcnt_nxt = wcnt - 4'd1;
        if (wcnt == 4'd1) begin
          do_access = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and wait-count registers.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Hold the accepted request for the access at the end of the wait period.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      r_we    <= 1'b0;
      r_byte  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (capture) begin
      r_we    <= req_we;
      r_byte  <= req_byte;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Response registers load on the access edge and stay put until the next access.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (do_access) begin
      rsp_rdata <= (a_we || a_mis) ? '0 : load_data;
      rsp_err   <= a_mis;
    end
  end

`ifdef DMEM_STATS_EN
  logic rsp_we;

  // Saturating counts of successful loads and stores, bumped when the response is taken.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rsp_we <= 1'b0;
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (do_access) begin
        rsp_we <= a_we;
      end
      if ((state == RESP) && rsp_ready && !rsp_err) begin
        if (rsp_we && (wr_cnt != 16'hFFFF)) begin
          wr_cnt <= wr_cnt + 16'd1;
        end
        if (!rsp_we && (rd_cnt != 16'hFFFF)) begin
          rd_cnt <= rd_cnt + 16'd1;
        end
      end
    end
  end
`endif

  dmem_array #(
    .DBG_AW(DBG_AW)
  ) u_array (
    .clk      (clk),
    .rst_n    (RST),
    .we       (arr_we),
    .idx      (a_addr[9:2]),
    .wdata    (arr_wdata),
    .rdata    (arr_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised and directed bench for dmem_responder against a word-array reference model.
// Latency: each request is checked to raise rsp_valid WAIT_CYCLES+1 edges after accept.
// Backpressure: rsp_ready is held low for random stretches to check that responses hold.
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        RST = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [3:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
`ifdef DMEM_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;
  int          exp_rd = 0, exp_wr = 0;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_mem [256];

  dmem_responder #(
    .WAIT_CYCLES(W),
    .DBG_AW(4)
  ) dut (
    .clk       (clk),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
`ifdef DMEM_STATS_EN
    ,
    .rd_cnt    (rd_cnt),
    .wr_cnt    (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: memory as an array of words, byte lanes handled with shifts and masks.
  task automatic model(input bit we, input bit byt, input logic [9:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output bit err);
    int w;
    int lane;
    w    = int'(addr) / 4;
    lane = int'(addr) % 4;
    err  = !byt && (lane != 0);
    rd   = 32'h0;
    if (!err) begin
      if (we) begin
        if (byt)
          ref_mem[w] = (ref_mem[w] & ~(32'hFF << (8*lane))) | ({24'h0, wd[7:0]} << (8*lane));
        else
          ref_mem[w] = wd;
      end else begin
        rd = byt ? ((ref_mem[w] >> (8*lane)) & 32'hFF) : ref_mem[w];
      end
    end
  endtask

  task automatic check_dbg(input int idx, input string tag);
    dbg_addr = idx[3:0];
    #1;
    check(tag, dbg_data, ref_mem[idx]);
  endtask

  task automatic do_req(input bit we, input bit byt, input logic [9:0] addr, input logic [31:0] wd,
                        input int hold, input string tag);
    logic [31:0] exp_d;
    bit          exp_e;
    bit          hold_bad;
    int          n;
    int          k;
    model(we, byt, addr, wd, exp_d, exp_e);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = byt;
    req_addr  = addr;
    req_wdata = wd;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " req_ready before accept"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check({tag, " req_ready after accept"}, {31'b0, req_ready}, 32'd0);
    n = 1;
    while (!rsp_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, " latency"}, n, W + 1);
    check({tag, " rdata"}, rsp_rdata, exp_d);
    check({tag, " err"}, {31'b0, rsp_err}, {31'b0, exp_e});
    hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== exp_d || rsp_err !== exp_e)
        hold_bad = 1'b1;
    end
    check({tag, " hold stable"}, {31'b0, hold_bad}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, " rsp_valid after take"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, " req_ready after take"}, {31'b0, req_ready}, 32'd1);
`ifdef DMEM_STATS_EN
    if (!exp_e) begin
      if (we) exp_wr++;
      else exp_rd++;
    end
`endif
  endtask

  initial begin
    logic [9:0]  ra;
    logic [31:0] rw;
    bit          rwe, rby;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", {31'b0, rsp_err}, 32'd0);
    check_dbg(0, "reset dbg0");
    @(negedge clk);
    RST = 1'b1;

    // Word store / load and debug view
    do_req(1'b1, 1'b0, 10'h008, 32'hDEADBEEF, 0, "sw 008");
    do_req(1'b0, 1'b0, 10'h008, 32'h0, 0, "lw 008");
    check_dbg(2, "dbg word2");
    check("dbg word2 const", dbg_data, 32'hDEADBEEF);

    // Byte store and byte load
    do_req(1'b1, 1'b1, 10'h009, 32'h00000055, 0, "sb 009");
    do_req(1'b0, 1'b0, 10'h008, 32'h0, 0, "lw 008 merged");
    check("merged word", dut.rsp_rdata, 32'hDEAD55EF);
    do_req(1'b0, 1'b1, 10'h00B, 32'h0, 0, "lb 00B");

    // Misaligned word accesses
    do_req(1'b1, 1'b0, 10'h004, 32'h12345678, 0, "sw 004");
    do_req(1'b0, 1'b0, 10'h006, 32'h0, 0, "lw 006 misaligned");
    do_req(1'b1, 1'b0, 10'h005, 32'hCAFEF00D, 0, "sw 005 misaligned");
    check_dbg(1, "dbg word1 unchanged");

    // Backpressure on the response channel
    do_req(1'b0, 1'b0, 10'h008, 32'h0, 5, "lw backpressure");

    // Reset during the wait period of a store
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_byte  = 1'b0;
    req_addr  = 10'h010;
    req_wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    RST = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
`ifdef DMEM_STATS_EN
    exp_rd = 0;
    exp_wr = 0;
`endif
    #1;
    check("mid-reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid-reset req_ready", {31'b0, req_ready}, 32'd1);
    check_dbg(2, "mid-reset dbg2 cleared");
    repeat (2) @(posedge clk);
    @(negedge clk);
    RST = 1'b1;
    do_req(1'b0, 1'b0, 10'h010, 32'h0, 0, "lw 010 after reset");
    check_dbg(4, "dbg word4 after reset");

    // Random traffic, mostly in the debug-visible window
    for (int t = 0; t < 60; t++) begin
      rwe = bit'($urandom_range(0, 1));
      rby = bit'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 63));
      rw  = $urandom;
      do_req(rwe, rby, ra, rw, int'($urandom_range(0, 3)), "rand");
      check_dbg(int'($urandom_range(0, 15)), "rand dbg");
    end

`ifdef DMEM_STATS_EN
    check("rd_cnt", {16'h0, rd_cnt}, exp_rd);
    check("wr_cnt", {16'h0, wr_cnt}, exp_wr);
    @(negedge clk);
    force dut.rd_cnt = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.rd_cnt;
    do_req(1'b0, 1'b0, 10'h000, 32'h0, 0, "lw saturate");
    check("rd_cnt saturated", {16'h0, rd_cnt}, 32'h0000FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
